// File: rtl/clk_enable_pkg.sv
// Shared types and default constants for the clock-enable generator.
package clk_enable_pkg;

  // Reset-sequencing FSM states.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  // Default parameter values: lock settle time, clk rate in kHz, pixel rate in kHz.
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_ACC_MOD     = 174000;
  localparam int DEF_PIX_INC     = 6144;

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock signal.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same edge,
      // giving a true two-stage chain regardless of statement order.
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/clk_enable_gen.sv
// Reset sequencer and fractional clock-enable generator driven by the PLL clock.
// Downstream reset is released only after the PLL lock has been stable for
// LOCK_CYCLES cycles; ce_pix is derived with a phase accumulator so that its
// average rate is exactly PIX_INC/ACC_MOD of clk, and ce_cpu is every other ce_pix.
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int ACC_MOD     = DEF_ACC_MOD,
  parameter int PIX_INC     = DEF_PIX_INC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_lock,
  output logic sys_reset_n,
  output logic ce_pix,
  output logic ce_cpu
);

  localparam int ACC_W = clog2_min1(ACC_MOD);
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = clog2_min1(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [SUM_W-1:0] SUM_MOD  = SUM_W'(ACC_MOD);
  localparam logic [SUM_W-1:0] SUM_INC  = SUM_W'(PIX_INC);

  // Reject parameter sets that cannot produce a valid enable pattern.
  if (PIX_INC <= 0 || PIX_INC >= ACC_MOD || LOCK_CYCLES <= 0) begin : g_param_check
    $error("clk_enable_gen: need 0 < PIX_INC < ACC_MOD and LOCK_CYCLES > 0");
  end

  logic             w_lock_s;
  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  logic [SUM_W-1:0] w_sum;
  logic             w_wrap;
  logic             w_run_hold;
  logic             r_toggle;
  logic             r_sys_reset_n;
  logic             r_ce_pix;
  logic             r_ce_cpu;

  lock_sync u_lock_sync (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_async(pll_lock),
    .o_sync (w_lock_s)
  );

  // FSM state and settle counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and settle-count logic; any loss of lock returns to WAIT_LOCK.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next_state = r_state;
    w_cnt_next   = '0;
    unique case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) w_next_state = SETTLE;
      end
      SETTLE: begin
        if (!w_lock_s) begin
          w_next_state = WAIT_LOCK;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = RUN;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!w_lock_s) w_next_state = WAIT_LOCK;
      end
      default: w_next_state = WAIT_LOCK;
    endcase
  end

  // Accumulator arithmetic: sum is one bit wider than acc so it never overflows.
  always_comb begin
    w_sum      = {1'b0, r_acc} + SUM_INC;
    w_wrap     = (w_sum >= SUM_MOD);
    w_acc_next = w_wrap ? ACC_W'(w_sum - SUM_MOD) : ACC_W'(w_sum);
    // Accumulate only on edges that start and stay in RUN, so the first
    // accumulation happens on the edge after sys_reset_n rises.
    w_run_hold = (r_state == RUN) && (w_next_state == RUN);
  end

  // Output registers: downstream reset, phase accumulator and clock enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sys_reset_n <= 1'b0;
      r_acc         <= '0;
      r_toggle      <= 1'b0;
      r_ce_pix      <= 1'b0;
      r_ce_cpu      <= 1'b0;
    end else begin
      r_sys_reset_n <= (w_next_state == RUN);
      if (!w_run_hold) begin
        r_acc    <= '0;
        r_toggle <= 1'b0;
        r_ce_pix <= 1'b0;
        r_ce_cpu <= 1'b0;
      end else begin
        r_acc    <= w_acc_next;
        r_ce_pix <= w_wrap;
        // ce_cpu fires when the toggle is already set, i.e. on the 2nd, 4th, ... ce_pix.
        r_ce_cpu <= w_wrap && r_toggle;
        if (w_wrap) r_toggle <= ~r_toggle;
      end
    end
  end

  assign sys_reset_n = r_sys_reset_n;
  assign ce_pix      = r_ce_pix;
  assign ce_cpu      = r_ce_cpu;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed testbench for clk_enable_gen (LOCK_CYCLES=16, default accumulator).
module tb_clk_enable_gen;

  localparam int L        = 16;
  localparam int MOD      = 174000;
  localparam int INC      = 6144;
  localparam int FIRST    = 29;     // ceil(174000/6144)
  localparam int RUN_SPAN = 20000;  // RUN edges observed in the long run

  logic clk;
  logic reset_n;
  logic pll_lock;
  logic sys_reset_n;
  logic ce_pix;
  logic ce_cpu;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  clk_enable_gen #(
    .LOCK_CYCLES(L),
    .ACC_MOD    (MOD),
    .PIX_INC    (INC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .sys_reset_n(sys_reset_n),
    .ce_pix     (ce_pix),
    .ce_cpu     (ce_cpu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous invariant monitor: no enable without released reset, no ce_cpu without ce_pix.
  always @(negedge clk) begin
    if (reset_n) begin
      if ((ce_pix && !sys_reset_n) || (ce_cpu && !sys_reset_n) || (ce_cpu && !ce_pix))
        viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then move to the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called right after pll_lock (or reset_n) has been raised with the other held high:
  // sys_reset_n must rise on edge 3+L, then the first ce_pix lands 29 edges later.
  task automatic expect_release(input string tag);
    for (int e = 1; e <= 3 + L; e++) begin
      tick();
      check({tag, "_rst"}, sys_reset_n, (e == 3 + L) ? 1 : 0);
      check({tag, "_pix_pre"}, ce_pix, 0);
    end
    for (int k = 1; k <= FIRST; k++) begin
      tick();
      check({tag, "_pix_first"}, ce_pix, (k == FIRST) ? 1 : 0);
      check({tag, "_cpu_first"}, ce_cpu, 0);
    end
  endtask

  initial begin
    int    pix_cnt;
    int    cpu_cnt;
    int    last_pix;
    int    gap_bad;
    int    par_bad;
    int    drop_bad;
    int    hold;
    longint exp_pix;

    // Reset state, no clock edge needed.
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    #2;
    check("reset_sys", sys_reset_n, 0);
    check("reset_pix", ce_pix, 0);
    check("reset_cpu", ce_cpu, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wait_lock_sys", sys_reset_n, 0);
    end

    // Lock rises with LOCK_CYCLES=16: release on edge 19, first ce_pix 29 edges later.
    pll_lock = 1'b1;
    expect_release("A");

    // Long RUN window: pulse count, ce_cpu count/phase and pulse spacing.
    pix_cnt  = 1;
    cpu_cnt  = 0;
    last_pix = FIRST;
    gap_bad  = 0;
    par_bad  = 0;
    drop_bad = 0;
    for (int n = FIRST + 1; n <= RUN_SPAN; n++) begin
      tick();
      if (!sys_reset_n) drop_bad++;
      if (ce_pix) begin
        pix_cnt++;
        if (n - last_pix != 28 && n - last_pix != 29) gap_bad++;
        last_pix = n;
        if (ce_cpu !== ((pix_cnt % 2) == 0)) par_bad++;
      end
      if (ce_cpu) cpu_cnt++;
    end
    exp_pix = (longint'(RUN_SPAN) * INC) / MOD;
    check("run_pix_count", pix_cnt, 32'(exp_pix));
    check("run_cpu_count", cpu_cnt, 32'(exp_pix / 2));
    check("run_gap_bad", gap_bad, 0);
    check("run_cpu_phase_bad", par_bad, 0);
    check("run_sys_drop", drop_bad, 0);

    // Lock lost in RUN: all outputs low by the 3rd edge; relock repeats the full settle.
    pll_lock = 1'b0;
    repeat (3) tick();
    check("D_drop_sys", sys_reset_n, 0);
    check("D_drop_pix", ce_pix, 0);
    check("D_drop_cpu", ce_cpu, 0);
    repeat (5) tick();
    pll_lock = 1'b1;
    expect_release("D");

    // One-cycle lock glitch at settle count 10 restarts the settle count.
    pll_lock = 1'b0;
    repeat (6) tick();
    pll_lock = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("C_settle_sys", sys_reset_n, 0);
    end
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    expect_release("C");

    // Asynchronous reset mid-RUN between edges, then restart with lock held high.
    repeat (50) tick();
    check("E_pre_sys", sys_reset_n, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("E_async_sys", sys_reset_n, 0);
    check("E_async_pix", ce_pix, 0);
    check("E_async_cpu", ce_cpu, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_release("E");

    // Random lock toggling with varied hold lengths; invariants watched by the monitor.
    for (int i = 0; i < 200; i++) begin
      pll_lock = $urandom_range(0, 1) == 1;
      hold = $urandom_range(1, 60);
      repeat (hold) tick();
    end
    check("random_invariant_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 The block SHALL have parameter LOCK_CYCLES, default 1024; continuous synchronized-lock cycles required before reset release.
REQ-002 The block SHALL have parameter ACC_MOD, default 174000; accumulator modulus, the clk frequency in kHz.
REQ-003 The block SHALL have parameter PIX_INC, default 6144; accumulator increment, the ce_pix rate in kHz.
REQ-004 The block SHALL have port clk, input, 1 bit; the PLL output clock, sole clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit; reset, asynchronous and active-low.
REQ-006 The block SHALL have port pll_lock, input, 1 bit; the PLL lock output, treated as asynchronous.
REQ-007 The block SHALL have port sys_reset_n, output, 1 bit; active-low reset for downstream logic, registered.
REQ-008 The block SHALL have port ce_pix, output, 1 bit; single-cycle pixel clock-enable pulse, registered.
REQ-009 The block SHALL have port ce_cpu, output, 1 bit; single-cycle CPU clock-enable pulse at half the ce_pix rate, registered.

Function
REQ-010 pll_lock SHALL pass through a 2-FF synchronizer (lock_s) before any use.
REQ-011 FSM states SHALL be WAIT_LOCK, SETTLE and RUN.
REQ-012 In WAIT_LOCK, when lock_s=1 the FSM SHALL go to SETTLE with the settle counter at 0.
REQ-013 In SETTLE, when lock_s=0 the FSM SHALL go to WAIT_LOCK and the counter SHALL clear.
REQ-014 In SETTLE, otherwise, the counter SHALL increment each cycle, and when it equals LOCK_CYCLES-1 the FSM SHALL go to RUN.
REQ-015 In RUN, when lock_s=0 the FSM SHALL go to WAIT_LOCK on the next edge.
REQ-016 sys_reset_n SHALL be 1 exactly while the FSM is in RUN; it rises 3+LOCK_CYCLES edges after pll_lock rises (first sampling edge = edge 1).
REQ-017 Outside RUN, the accumulator (ceil(log2(ACC_MOD)) bits) SHALL be 0 and ce_pix, ce_cpu and the divide toggle SHALL be 0.
REQ-018 In RUN, each edge SHALL compute sum=acc+PIX_INC.
REQ-019 If sum>=ACC_MOD then acc<=sum-ACC_MOD and ce_pix<=1; else acc<=sum and ce_pix<=0.
REQ-020 No intermediate value SHALL overflow; sum SHALL be one bit wider than acc.
REQ-021 The first ce_pix SHALL be high 29 edges after the edge where sys_reset_n rises (defaults: ceil(174000/6144)=29).
REQ-022 Subsequent ce_pix spacing SHALL be 28 or 29 cycles only.
REQ-023 Over any ACC_MOD consecutive RUN cycles there SHALL be exactly PIX_INC ce_pix pulses.
REQ-024 The divide toggle SHALL flip on each ce_pix; ce_cpu SHALL pulse on the same cycle as every second ce_pix, starting with the 2nd after RUN entry.
REQ-025 On pll_lock falling during RUN, sys_reset_n, ce_pix and ce_cpu SHALL all be 0 no later than the 3rd edge.
REQ-026 A lock glitch of any length during SETTLE SHALL restart the settle count from 0.
REQ-027 Parameters with PIX_INC=0, PIX_INC>=ACC_MOD or LOCK_CYCLES=0 SHALL cause an elaboration error.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear the synchronizer, FSM (to WAIT_LOCK), counter, accumulator and toggle, with sys_reset_n, ce_pix and ce_cpu at 0.
REQ-029 No clock edge SHALL be needed for reset to take effect.
REQ-030 After reset_n rises, the block SHALL behave as if in WAIT_LOCK with lock_s=0.

Structure
REQ-031 The state enumeration and default parameter constants SHALL live in shared package clk_enable_pkg.
REQ-032 The 2-FF synchronizer SHALL be sub-module lock_sync, async active-low reset, clearing to 0.

Verification
REQ-033 LOCK_CYCLES=16, pll_lock=1 constant, reset_n released -> sys_reset_n rises exactly at edge 19; no ce_pix before that.
REQ-034 Defaults, 174000 RUN cycles -> ce_pix count 6144, ce_cpu count 3072, every ce_pix gap 28 or 29; first ce_pix 29 edges after sys_reset_n rises.
REQ-035 LOCK_CYCLES=16, pll_lock low for 1 cycle at settle count 10 -> count restarts at 0; sys_reset_n rises 16 edges after lock_s returns high, not earlier.
REQ-036 pll_lock dropped in RUN -> sys_reset_n, ce_pix and ce_cpu all 0 within 3 edges; relock -> full settle again, then first ce_pix 29 edges after release.
REQ-037 reset_n pulled low mid-RUN between clock edges -> all outputs 0 before the next edge; restart behaves as REQ-033.
REQ-038 Random pll_lock toggling, 10^5 cycles -> ce_pix/ce_cpu never high while sys_reset_n=0; ce_cpu never high without ce_pix.
